load_data_sequencer: RTL
========================

// Module: load_data_sequencer
// PURPOSE
//   Sequences one scalar load at a time: accepts an LSU request, issues an 8-byte-aligned memory read,
//   waits for the response, then extracts the addressed byte/half/word/double.
//   Sign- or zero-extends the result to DATA_WIDTH and returns it on a valid/ready result port.
//   Sits between decode/LSU issue and the data-memory port. Owns the load-extension datapath.
// PARAMETERS
//   DATA_WIDTH      64  width of memory data and result; fixed at 64 (8-byte lanes)
//   ADDR_WIDTH      64  request and memory address width
//   TIMEOUT_CYCLES  16  max cycles in WAIT before abort with error; legal range 2..256
// PORTS
//   clock                  in   1           single clock, rising edge
//   reset_n                in   1           asynchronous, active-low reset
//   request_valid          in   1           load request present
//   request_ready          out  1           sequencer can accept a request
//   request_address        in   ADDR_WIDTH  byte address
//   request_funct3         in   3           000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
//   memory_read_valid      out  1           read command valid
//   memory_read_ready      in   1           memory accepts the command
//   memory_read_address    out  ADDR_WIDTH  request_address with bits [2:0] forced to 0
//   memory_response_valid  in   1           read data valid (one-cycle pulse)
//   memory_response_data   in   DATA_WIDTH  8-byte line containing the target
//   result_valid           out  1           result available
//   result_ready           in   1           consumer takes result
//   result_data            out  DATA_WIDTH  extended load value; 0 when result_error=1
//   result_error           out  1           timeout, illegal funct3 or (optionally) misalignment
// BEHAVIOUR
//   Reset (async assert, sync deassert): state=IDLE, request_ready=1, all other outputs 0, timeout counter=0.
//   FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE. Registered outputs, decoded from state.
//   IDLE: request_ready=1. On request_valid, latch address/funct3.
//     funct3=111 -> DONE with error; otherwise -> ISSUE.
//   ISSUE: memory_read_valid=1, address held stable until memory_read_ready; on handshake -> WAIT, counter=0.
//   WAIT: counter increments each cycle. On memory_response_valid, capture formatted data -> DONE.
//     If counter==TIMEOUT_CYCLES-1 without response -> DONE, error=1, data=0.
//     A response arriving in the timeout cycle wins: no error.
//   DONE: result_valid=1; data/error held stable until result_ready; on handshake -> IDLE.
//   Min latency: accept edge E0, read handshake E1, response captured E2; result_valid high after E2.
//   No back-to-back accept: request_ready=0 in ISSUE/WAIT/DONE.
//   memory_response_valid outside WAIT is ignored (no state change, no capture).
//   Format: off=address[2:0]; line >> (off*8); keep low 8/16/32/64 bits per funct3[1:0];
//     funct3[2]=0 sign-extend from MSB of kept field, =1 zero-extend.
//   Reset mid-transaction: return to IDLE, drop the outstanding read; a later stray response is ignored.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined: address not a multiple of access size (e.g. LW at off 2, LD at off!=0)
//     -> IDLE goes directly to DONE, error=1, data=0, no memory read issued.
//   MISALIGN_TRAP_EN undefined: off is masked to size alignment (off & ~(size-1)), never an error;
//     off=3 for LH reads bytes [3:2].
// STRUCTURE
//   load_sequencer_pkg: state_t enum {IDLE,ISSUE,WAIT,DONE}; funct3 localparams (LB..LWU);
//     access_size_t {BYTE,HALF,WORD,DOUBLE}; function funct3_to_size.
//   Sub-module load_extract_extend (combinational): line, off, funct3 -> extended DATA_WIDTH value.
//   FSM, counter and handshake logic stay in load_data_sequencer.
// TESTING
//   LB addr 0x1007, line 0x80FF_0000_0000_0000 -> result_data 0xFFFF_FFFF_FFFF_FF80, error 0.
//   LHU addr 0x2006, line 0xBEEF_0000_0000_0000 -> 0x0000_0000_0000_BEEF.
//   LW addr 0x2004, line 0x8000_0001_0000_0000 -> 0xFFFF_FFFF_8000_0001.
//   memory_read_ready low 5 cycles -> memory_read_valid/address held stable; no timeout counting in ISSUE.
//   No response for 16 cycles -> result_error 1, data 0. Response on 16th WAIT cycle -> no error.
//   result_ready low 3 cycles -> result held; funct3=111 -> error without a memory read.
//   LW addr 0x3002: with MISALIGN_TRAP_EN -> error, no read; without -> data from bytes [3:0].

Source files
------------

// File: rtl/load_sequencer_pkg.sv
// Shared types for the scalar load sequencer: FSM states, funct3 codes,
// access sizes and size helpers.
package load_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } access_size_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    function automatic access_size_t funct3_to_size(input logic [2:0] funct3);
        return access_size_t'(funct3[1:0]);
    endfunction

    // Low offset bits that must be zero for a naturally aligned access
    function automatic logic [2:0] size_mask(input access_size_t size);
        logic [2:0] mask;
        mask = 3'b000;
        unique case (size)
            BYTE:   mask = 3'b000;
            HALF:   mask = 3'b001;
            WORD:   mask = 3'b011;
            DOUBLE: mask = 3'b111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/load_extract_extend.sv
// Picks the addressed byte/half/word/double out of an 8-byte line and
// sign- or zero-extends it; the offset is forced to natural alignment.
module load_extract_extend
    import load_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] line,
    input  logic [2:0]            off,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] value
);

    access_size_t          size;
    logic [2:0]            off_aligned;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  sign;

    always_comb begin
        size        = funct3_to_size(funct3);
        off_aligned = off & ~size_mask(size);
        shifted     = line >> {off_aligned, 3'b000};
        sign        = 1'b0;
        value       = shifted;
        unique case (size)
            BYTE: begin
                sign  = ~funct3[2] & shifted[7];
                value = {{(DATA_WIDTH-8){sign}}, shifted[7:0]};
            end
            HALF: begin
                sign  = ~funct3[2] & shifted[15];
                value = {{(DATA_WIDTH-16){sign}}, shifted[15:0]};
            end
            WORD: begin
                sign  = ~funct3[2] & shifted[31];
                value = {{(DATA_WIDTH-32){sign}}, shifted[31:0]};
            end
            DOUBLE: begin
                value = shifted;
            end
        endcase
    end

endmodule

// File: rtl/load_data_sequencer.sv
// One-at-a-time scalar load sequencer: IDLE -> ISSUE -> WAIT -> DONE.
// Define MISALIGN_TRAP_EN to trap misaligned loads instead of masking the offset.
module load_data_sequencer
    import load_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  request_valid,
    output logic                  request_ready,
    input  logic [ADDR_WIDTH-1:0] request_address,
    input  logic [2:0]            request_funct3,
    output logic                  memory_read_valid,
    input  logic                  memory_read_ready,
    output logic [ADDR_WIDTH-1:0] memory_read_address,
    input  logic                  memory_response_valid,
    input  logic [DATA_WIDTH-1:0] memory_response_data,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [DATA_WIDTH-1:0] result_data,
    output logic                  result_error
);

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                state;
    logic [7:0]            count;
    logic [2:0]            funct3_q;
    logic [2:0]            off_q;
    logic                  misaligned;
    logic [DATA_WIDTH-1:0] extended;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = |(request_address[2:0]
                        & size_mask(funct3_to_size(request_funct3)));
`else
    assign misaligned = 1'b0;
`endif

    load_extract_extend #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_extract (
        .line   (memory_response_data),
        .off    (off_q),
        .funct3 (funct3_q),
        .value  (extended)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            request_ready       <= 1'b1;
            memory_read_valid   <= 1'b0;
            memory_read_address <= '0;
            result_valid        <= 1'b0;
            result_data         <= '0;
            result_error        <= 1'b0;
            count               <= '0;
            funct3_q            <= '0;
            off_q               <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (request_valid) begin
                        funct3_q            <= request_funct3;
                        off_q               <= request_address[2:0];
                        memory_read_address <= {request_address[ADDR_WIDTH-1:3], 3'b000};
                        request_ready       <= 1'b0;
                        if (request_funct3 == F3_ILL || misaligned) begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                            result_error <= 1'b1;
                            result_data  <= '0;
                        end else begin
                            state             <= ISSUE;
                            memory_read_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (memory_read_ready) begin
                        memory_read_valid <= 1'b0;
                        count             <= '0;
                        state             <= WAIT;
                    end
                end
                WAIT: begin
                    // A response in the final cycle still beats the timeout
                    if (memory_response_valid) begin
                        result_data  <= extended;
                        result_error <= 1'b0;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else if (count == LAST) begin
                        result_data  <= '0;
                        result_error <= 1'b1;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid  <= 1'b0;
                        result_error  <= 1'b0;
                        result_data   <= '0;
                        request_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
